// File: rtl/seg_capture.sv
// Seven-segment display snooper: watches a multiplexed segment/anode bus and
// rebuilds the hex digits being displayed once each digit's drive is stable.
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  an_in,
  output logic [31:0] value,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_select,
  output logic [1:0]  dbg_state
);

  // Handshake note: there is no valid/ready pairing here; frame_done,
  // err_pattern and err_select are single-cycle strobes, and value/digit_valid
  // are level outputs that change only on the edge of a capture.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  count;
  logic [6:0]  prev_seg;
  logic [7:0]  prev_an;
  logic        prev_multi;
  logic [7:0]  seen;

  logic [3:0]  zero_cnt;
  logic        one_sel;
  logic        multi_sel;
  logic [2:0]  sel_idx;
  logic        same_pair;
  logic [8:0]  count_inc;
  logic        capture_now;
  logic        dec_ok;
  logic [3:0]  dec_nib;
  logic [7:0]  seen_next;
  logic        unused_dp;

  // The decimal point carries no digit information.
  assign unused_dp = seg_in[7];

  always_comb begin
    zero_cnt = 4'd0;
    sel_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_in[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        sel_idx  = 3'(i);
      end
    end
  end

  assign one_sel   = (zero_cnt == 4'd1);
  assign multi_sel = (zero_cnt > 4'd1);
  assign same_pair = (seg_in[6:0] == prev_seg) && (an_in == prev_an);
  assign count_inc = {1'b0, count} + 9'd1;

  // Capture fires on the edge where the stable-sample count would hit the target.
  assign capture_now = one_sel && (state == SETTLE) && same_pair &&
                       (count_inc == 9'(STABLE_CYCLES));

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (seg_in[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  assign seen_next = seen | (8'b1 << sel_idx);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 8'd0;
      prev_seg    <= 7'd0;
      prev_an     <= 8'hFF;
      prev_multi  <= 1'b0;
      seen        <= 8'h00;
      value       <= 32'd0;
      digit_valid <= 8'h00;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_select  <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_select  <= multi_sel && !prev_multi;
      prev_multi  <= multi_sel;
      prev_seg    <= seg_in[6:0];
      prev_an     <= an_in;

      if (!one_sel) begin
        state <= IDLE;
        count <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            state <= SETTLE;
            count <= 8'd1;
          end
          SETTLE: begin
            if (!same_pair) begin
              count <= 8'd1;
            end else if (capture_now) begin
              state <= HOLD;
              count <= count_inc[7:0];
            end else begin
              count <= count_inc[7:0];
            end
          end
          HOLD: begin
            if (!same_pair) begin
              state <= SETTLE;
              count <= 8'd1;
            end
          end
          default: begin
            state <= IDLE;
            count <= 8'd0;
          end
        endcase
      end

      if (capture_now) begin
        if (dec_ok) begin
          value[{sel_idx, 2'b00} +: 4] <= dec_nib;
          digit_valid[sel_idx]         <= 1'b1;
        end else begin
          digit_valid[sel_idx] <= 1'b0;
          err_pattern          <= 1'b1;
        end
        // A full mask closes the frame and starts a fresh one on the same edge.
        if (seen_next == 8'hFF) begin
          frame_done <= 1'b1;
          seen       <= 8'h00;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: a run-length reference model predicts the
// outputs after every edge; a monitor compares the DUT one step behind.
module tb_seg_capture;

  localparam int STABLE = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  seg_in;
  logic [7:0]  an_in;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        err_pattern;
  logic        err_select;
  logic [1:0]  dbg_state;

  seg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_select  (err_select),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0] m_val [8];
  logic [7:0] m_valid;
  logic [7:0] m_seen;
  int         m_run;
  logic [6:0] m_last_seg;
  logic [7:0] m_last_an;
  bit         m_prev_multi;

  logic [42:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic model_edge(input logic [7:0] s, input logic [7:0] a, input logic r);
    logic fd, ep, es;
    int zeros, d, k;
    logic [31:0] v;
    fd = 0; ep = 0; es = 0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_val[i] = 4'h0;
      m_valid = 8'h00; m_seen = 8'h00; m_run = 0; m_prev_multi = 0;
    end else begin
      zeros = $countones(~a);
      es = (zeros > 1) && !m_prev_multi;
      m_prev_multi = (zeros > 1);
      if (zeros == 1) begin
        if (m_run > 0 && s[6:0] == m_last_seg && a == m_last_an) m_run++;
        else m_run = 1;
        m_last_seg = s[6:0];
        m_last_an  = a;
        if (m_run == STABLE) begin
          d = 0;
          for (int i = 0; i < 8; i++) if (!a[i]) d = i;
          k = -1;
          for (int j = 0; j < 16; j++) if (pat[j] == s[6:0]) k = j;
          if (k >= 0) begin
            m_val[d] = 4'(k);
            m_valid[d] = 1'b1;
          end else begin
            m_valid[d] = 1'b0;
            ep = 1;
          end
          m_seen[d] = 1'b1;
          if (m_seen == 8'hFF) begin
            fd = 1;
            m_seen = 8'h00;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    v = 32'd0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = m_val[i];
    exp_q.push_back({v, m_valid, fd, ep, es});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] s, input logic [7:0] a, input logic r);
    @(negedge clk);
    seg_in = s;
    an_in  = a;
    rst    = r;
    model_edge(s, a, r);
  endtask

  task automatic hold(input logic [7:0] s, input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) step(s, a, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [42:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {value, digit_valid, frame_done, err_pattern, err_select};
        n_checks++;
        if (act_v !== exp_v) begin
          n_errors++;
          $display("FAIL outputs t=%0t: value=%h dv=%h fd=%b ep=%b es=%b required value=%h dv=%h fd=%b ep=%b es=%b",
                   $time, act_v[42:11], act_v[10:3], act_v[2], act_v[1], act_v[0],
                   exp_v[42:11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] s, a;
    int n, d, b;
    rst = 1'b1; seg_in = 8'hFF; an_in = 8'hFF;
    step(8'hFF, 8'hFF, 1'b1);
    step(8'hFF, 8'hFF, 1'b1);

    // single digit 5 held on digit 0
    hold(8'h12, 8'hFE, 8);
    // digit 1: bouncing 3 then stable 4
    hold(8'h30, 8'hFD, 3);
    hold(8'h19, 8'hFD, 6);
    // full scan 1..8 completing a frame
    step(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) hold({1'b1, pat[i+1]}, ~(8'h01 << i), 6);
    hold(8'hFF, 8'hFF, 2);
    // illegal pattern on digit 2
    hold(8'h7F, 8'hFB, 5);
    // multi-select held, then reset in the middle of a settle
    hold(8'h12, 8'hFC, 10);
    hold(8'h40, 8'hFE, 2);
    step(8'h40, 8'hFE, 1'b1);
    hold(8'h40, 8'hFE, 6);

    // randomized bursts
    for (int t = 0; t < 400; t++) begin
      n = $urandom_range(1, 8);
      d = $urandom_range(0, 99);
      if (d < 70) a = ~(8'h01 << $urandom_range(0, 7));
      else if (d < 82) a = 8'hFF;
      else begin
        b = $urandom_range(0, 7);
        a = ~((8'h01 << b) | (8'h01 << ((b + 1 + $urandom_range(0, 6)) % 8)));
      end
      if ($urandom_range(0, 99) < 80) s = {1'b1, pat[$urandom_range(0, 15)]};
      else s = 8'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) begin
        s[7] = 1'($urandom_range(0, 1));
        step(s, a, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 2..255: number of consecutive rising edges an input (seg_in, an_in) pair must be sampled unchanged before capture.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port seg_in  input  8  active-low segment bus; bit0=a ... bit6=g; bit7 (dp) ignored.
REQ-005 SHALL have port an_in  input  8  active-low digit select; bit i low = digit i driven.
REQ-006 SHALL have port value  output  32  captured hex digits; digit i in bits [4i+3:4i].
REQ-007 SHALL have port digit_valid  output  8  bit i = 1 when digit i last captured a legal pattern.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the last pulse.
REQ-009 SHALL have port err_pattern  output  1  one-cycle pulse when a captured pattern is not in the decode table.
REQ-010 SHALL have port err_select  output  1  one-cycle pulse when more than one an_in bit goes low.

Function
REQ-011 SHALL decode seg_in[6:0] (hex) as: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F; any other value is illegal.
REQ-012 SHALL implement states IDLE, SETTLE, HOLD.
REQ-013 SHALL hold in IDLE, stability count 0, while an_in is all-ones (blank) or has more than one zero bit; no capture occurs.
REQ-014 SHALL enter SETTLE with count 1 on the edge where an_in has exactly one zero bit and IDLE or HOLD sees a changed pair.
REQ-015 SHALL in SETTLE increment count on each edge where the pair equals the previous edge's sample; any difference restarts count at 1 with the new pair (or goes to IDLE per REQ-013).
REQ-016 SHALL capture on the edge where count would reach STABLE_CYCLES, then move to HOLD; outputs updated by that edge (latency = STABLE_CYCLES edges from first stable sample).
REQ-017 SHALL in HOLD not capture again until the pair changes; a change follows REQ-013/REQ-014.
REQ-018 SHALL on legal capture for digit i write the decoded nibble into value[4i+3:4i] and set digit_valid[i]=1.
REQ-019 SHALL on illegal capture for digit i leave the nibble unchanged, clear digit_valid[i], and pulse err_pattern for one cycle.
REQ-020 SHALL pulse err_select for one cycle on the first edge of each contiguous run of multi-select samples; no repeat pulse while the condition persists.
REQ-021 SHALL keep an 8-bit seen mask; each capture (legal or illegal) sets bit i.
REQ-022 SHALL, when a capture completes seen=FF, assert frame_done in the same update as that capture and clear seen to 00 on that edge.
REQ-023 SHALL treat recapture of an already-seen digit as an overwrite of value/digit_valid with no mask change.
REQ-024 SHALL NOT require any particular digit scan order.

Reset
REQ-025 SHALL on rst=1 at an edge set value=0, digit_valid=00, frame_done=0, err_pattern=0, err_select=0, seen=00, count=0, state IDLE.
REQ-026 SHALL give rst priority over every capture and pulse on the same edge; a SETTLE in progress is discarded.
REQ-027 SHALL after rst deasserts treat the current input as new (first stable sample = count 1).

Verification
REQ-028 SHALL pass: an_in=FE, seg_in=12 held, STABLE_CYCLES=4 -> value[3:0]=5, digit_valid=01 after 4th edge; no further change while held.
REQ-029 SHALL pass: an_in=FD, seg_in alternates 30 for 3 edges then 19 held -> no capture of 3; value[7:4]=4 after 4 more edges.
REQ-030 SHALL pass: scan digits 0..7 with patterns for 1,2,...,8, each held 6 cycles -> value=87654321, digit_valid=FF, frame_done high exactly one cycle with digit 7 capture.
REQ-031 SHALL pass: an_in=FB, seg_in=7F held 4 edges -> err_pattern one-cycle pulse, digit_valid[2]=0, value[11:8] unchanged.
REQ-032 SHALL pass: an_in=FC held 10 cycles -> err_select single pulse, no capture; rst asserted at edge 3 of a SETTLE -> all outputs 0, no capture.
